// File: rtl/lga_pkg.sv
// Shared types and constants for the FHP lattice-gas neighbourhood pipeline.
package lga_pkg;

    localparam int CELL_W = 8;

    localparam int BIT_DIR0 = 0;
    localparam int BIT_DIR1 = 1;
    localparam int BIT_DIR2 = 2;
    localparam int BIT_DIR3 = 3;
    localparam int BIT_DIR4 = 4;
    localparam int BIT_DIR5 = 5;
    localparam int BIT_REST = 6;
    localparam int BIT_WALL = 7;

    typedef logic [CELL_W-1:0] cell_t;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/lga_window_if.sv
// Cell-stream input and 3x3 window output handshakes of the neighbourhood generator.
interface lga_window_if;
    import lga_pkg::*;

    logic  in_valid;
    logic  in_ready;
    cell_t in_cell;
    logic  out_valid;
    logic  out_ready;
    cell_t c0, c1, c2, c3, c4, c5, c6, c7, c8;
    logic  x;
    logic  out_last;

    modport master (
        output in_valid, in_cell, out_ready,
        input  in_ready, out_valid, c0, c1, c2, c3, c4, c5, c6, c7, c8, x, out_last
    );

    modport slave (
        input  in_valid, in_cell, out_ready,
        output in_ready, out_valid, c0, c1, c2, c3, c4, c5, c6, c7, c8, x, out_last
    );

endinterface

// File: rtl/lga_line_buf.sv
// One-row delay line: each enabled step returns the cell written DEPTH steps earlier.
module lga_line_buf
    import lga_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_en,
    input  cell_t i_din,
    output cell_t o_dout
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cell_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;

    assign o_dout = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/lga_window.sv
// Raster-stream 3x3 neighbourhood generator with boundary masking and row parity.
module lga_window
    import lga_pkg::*;
#(
    parameter int    GRID_W   = 64,
    parameter int    GRID_H   = 64,
    parameter cell_t BND_CELL = 8'h00
) (
    input logic         clk,
    input logic         rst,
    lga_window_if.slave bus
);
    localparam int COL_W = $clog2(GRID_W);
    localparam int ROW_W = $clog2(GRID_H);
    localparam int CNT_W = $clog2(GRID_W + 2);

    state_t           r_state, w_state_n;
    logic [COL_W-1:0] r_in_col, r_out_col;
    logic [ROW_W-1:0] r_in_row, r_out_row;
    logic [CNT_W-1:0] r_cnt;
    cell_t            r_t0, r_t1, r_m0, r_m1, r_b0, r_b1;
    cell_t            r_c [9];
    logic             r_out_valid, r_x, r_last;

    cell_t w_lb1, w_lb2, w_inj;
    cell_t w_nxt [9];
    cell_t w_msk [9];
    logic  w_in_ready, w_accept, w_step, w_load;
    logic  w_in_last, w_out_last, w_cnt_end;

    assign w_in_last  = (r_in_row == ROW_W'(GRID_H - 1)) && (r_in_col == COL_W'(GRID_W - 1));
    assign w_out_last = (r_out_row == ROW_W'(GRID_H - 1)) && (r_out_col == COL_W'(GRID_W - 1));
    assign w_cnt_end  = (r_cnt == CNT_W'(GRID_W));
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_state_n  = r_state;
        w_in_ready = 1'b0;
        w_step     = 1'b0;
        w_load     = 1'b0;
        w_inj      = bus.in_cell;
        case (r_state)
            FILL: begin
                w_in_ready = 1'b1;
                w_step     = bus.in_valid;
                if (bus.in_valid && w_cnt_end) w_state_n = RUN;
            end
            RUN: begin
                w_in_ready = !r_out_valid || bus.out_ready;
                w_step     = bus.in_valid && w_in_ready;
                w_load     = w_step;
                if (w_step && w_in_last) w_state_n = FLUSH;
            end
            FLUSH: begin
                w_inj  = BND_CELL;
                w_step = !r_out_valid || bus.out_ready;
                w_load = w_step;
                if (w_step && w_cnt_end) w_state_n = FILL;
            end
            default: w_state_n = FILL;
        endcase
    end

    lga_line_buf #(.DEPTH(GRID_W)) u_lb_row (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_step),
        .i_din  (w_inj),
        .o_dout (w_lb1)
    );

    lga_line_buf #(.DEPTH(GRID_W)) u_lb_prev (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_step),
        .i_din  (w_lb1),
        .o_dout (w_lb2)
    );

    // Output regs are loaded from the post-shift window so a window lands one cycle after its step.
    assign w_nxt = '{r_t0, r_t1, w_lb2, r_m0, r_m1, w_lb1, r_b0, r_b1, w_inj};

    always_comb begin
        w_msk = w_nxt;
        for (int unsigned i = 0; i < 9; i++) begin
            if (((i % 3 == 0) && (r_out_col == '0)) ||
                ((i % 3 == 2) && (r_out_col == COL_W'(GRID_W - 1))) ||
                ((i / 3 == 0) && (r_out_row == '0)) ||
                ((i / 3 == 2) && (r_out_row == ROW_W'(GRID_H - 1)))) begin
                w_msk[i] = BND_CELL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_in_col    <= '0;
            r_in_row    <= '0;
            r_out_col   <= '0;
            r_out_row   <= '0;
            r_cnt       <= '0;
            r_t0        <= '0;
            r_t1        <= '0;
            r_m0        <= '0;
            r_m1        <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_c         <= '{default: '0};
            r_out_valid <= 1'b0;
            r_x         <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_accept) begin
                if (r_in_col == COL_W'(GRID_W - 1)) begin
                    r_in_col <= '0;
                    r_in_row <= (r_in_row == ROW_W'(GRID_H - 1)) ? '0 : r_in_row + 1'b1;
                end else begin
                    r_in_col <= r_in_col + 1'b1;
                end
            end
            if (w_step && (r_state != RUN)) begin
                r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
            end
            if (w_step) begin
                r_t0 <= r_t1;
                r_t1 <= w_lb2;
                r_m0 <= r_m1;
                r_m1 <= w_lb1;
                r_b0 <= r_b1;
                r_b1 <= w_inj;
            end
            if (w_load) begin
                r_c         <= w_msk;
                r_x         <= r_out_row[0];
                r_last      <= w_out_last;
                r_out_valid <= 1'b1;
                if (r_out_col == COL_W'(GRID_W - 1)) begin
                    r_out_col <= '0;
                    r_out_row <= (r_out_row == ROW_W'(GRID_H - 1)) ? '0 : r_out_row + 1'b1;
                end else begin
                    r_out_col <= r_out_col + 1'b1;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.c0        = r_c[0];
    assign bus.c1        = r_c[1];
    assign bus.c2        = r_c[2];
    assign bus.c3        = r_c[3];
    assign bus.c4        = r_c[4];
    assign bus.c5        = r_c[5];
    assign bus.c6        = r_c[6];
    assign bus.c7        = r_c[7];
    assign bus.c8        = r_c[8];
    assign bus.x         = r_x;
    assign bus.out_last  = r_last;

endmodule
